// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO in front of the
// framing FSM. Frame: start, DATA_BITS LSB first, optional parity, stop bits.
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Tx_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    // Ready looks only at the registered count, so a full FIFO never accepts
    // a write even when the FSM pops in the same cycle.
    always_comb begin
        ready    = (count_q < CW'(FIFO_DEPTH));
        push     = i_Tx_DV && ready;
        ovf_d    = i_Tx_DV && !ready;
        head     = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_Tx_Byte;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;
        done_d    = 1'b0;
        bit_end   = (clk_cnt_q == 8'(CLKS_PER_BIT - 1));
        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ (PARITY == 1);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == IW'(STOP_BITS - 1)) begin
                        done_d    = 1'b1;
                        bit_idx_d = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (^head) ^ (PARITY == 1);
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Line and active flag are registered from the next state so they change
    // on the same edge as the state itself.
    always_comb begin
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
            S_PARITY: serial_d = par_d;
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_d != S_IDLE);
    end

    assign o_Tx_Ready    = ready;
    assign o_Tx_Serial   = serial_q;
    assign o_Tx_Active   = active_q;
    assign o_Tx_Done     = done_q;
    assign o_Tx_Overflow = ovf_q;
    assign o_Fifo_Count  = count_q;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-006 SHALL have port i_Clock, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-007 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_Tx_DV, input, 1 bit: write strobe; one write per cycle while high.
REQ-009 SHALL have port i_Tx_Byte, input, DATA_BITS bits: the word to transmit.
REQ-010 SHALL have port o_Tx_Ready, output, 1 bit: high when FIFO count < FIFO_DEPTH.
REQ-011 SHALL have port o_Tx_Serial, output, 1 bit, registered: the serial line.
REQ-012 SHALL have port o_Tx_Active, output, 1 bit: high from first start-bit cycle to last stop-bit cycle.
REQ-013 SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse per completed frame.
REQ-014 SHALL have port o_Tx_Overflow, output, 1 bit: one-cycle pulse per rejected write.
REQ-015 SHALL have port o_Fifo_Count, output, $clog2(FIFO_DEPTH)+1 bits: number of FIFO entries.

Function
REQ-016 SHALL accept a write when i_Tx_DV=1 and o_Tx_Ready=1; count rises the next cycle unless a pop occurs in the same cycle.
REQ-017 SHALL drop a write when i_Tx_DV=1 and o_Tx_Ready=0; FIFO unchanged; o_Tx_Overflow=1 in the following cycle.
REQ-018 SHALL use o_Tx_Ready from the current count only; a pop in the same cycle does not make a full FIFO accept.
REQ-019 SHALL accept a write into an empty FIFO; the popped word is the head before the edge, so an empty FIFO is never popped.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL, in IDLE with count>0: pop the head into the shift register, enter START, drive o_Tx_Serial=0 from the next cycle.
REQ-022 SHALL, in IDLE with count=0: keep o_Tx_Serial=1 and o_Tx_Active=0.
REQ-023 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a bit counter that clears at each bit boundary.
REQ-024 SHALL transmit data LSB first: START goes to DATA; DATA goes to PARITY after DATA_BITS bits when PARITY!=0, otherwise to STOP.
REQ-025 SHALL compute parity over the data bits: odd makes the total ones in data+parity odd; even makes it even.
REQ-026 SHALL drive the line to 1 for STOP_BITS bit periods in STOP.
REQ-027 SHALL make the frame exactly CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles long.
REQ-028 SHALL pulse o_Tx_Done=1 in the cycle after the last stop-bit cycle.
REQ-029 SHALL, at the end of STOP with count>0, pop and enter START directly: no idle cycle between frames, o_Tx_Active stays high.
REQ-030 SHALL, at the end of STOP with count=0, return to IDLE.
REQ-031 SHALL latch each word at pop; FIFO writes during a frame do not affect that frame.
REQ-032 SHALL return any unused state encoding to IDLE with o_Tx_Serial=1.

Reset
REQ-033 SHALL, on i_Reset=1 at a clock edge, set: state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overflow=0, counters 0, FIFO empty (o_Fifo_Count=0, o_Tx_Ready=1).
REQ-034 SHALL, on reset mid-frame, abort the frame: line high the next cycle, no o_Tx_Done pulse, queued words discarded.
REQ-035 SHALL ignore writes presented while i_Reset=1.

Verification
REQ-036 SHALL cover CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, write 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles, 44 cycles total, one o_Tx_Done pulse.
REQ-037 SHALL cover PARITY=1, write 0x00 -> parity bit 1; write 0xFF -> parity bit 1.
REQ-038 SHALL cover FIFO_DEPTH=4, i_Tx_DV high for 6 consecutive cycles with 0x01..0x06 from idle -> 0x01..0x05 sent back-to-back with no gap, 0x06 dropped, exactly one o_Tx_Overflow pulse, o_Tx_Done pulses 5 times.
REQ-039 SHALL cover DATA_BITS=5, STOP_BITS=2, PARITY=0, CLKS_PER_BIT=3, write 0x13 -> bits 0,1,1,0,0,1,1,1, 24 cycles total.
REQ-040 SHALL cover i_Reset asserted during the 3rd data bit with 2 words queued -> o_Tx_Serial=1 the next cycle, o_Fifo_Count=0, no o_Tx_Done, no further frames.
